// File: rtl/bikelight_mode_ctrl.sv
// bikelight_mode_ctrl: bike light mode sequencer.
// Short press steps the one-hot mode OFF->ON->BLINK->DIM->OFF; a long press
// forces OFF. Drives a registered LED output: steady, blink or dim PWM.
// Optional feature: define BIKELIGHT_AUTO_OFF_EN to enable the idle auto-off timer.
// The release pulse port is named rel because release is a reserved word.
module bikelight_mode_ctrl #(
    parameter int unsigned LONG_CYC = 16,
    parameter int unsigned BLINK_W  = 4,
    parameter int unsigned DIM_W    = 2,
    parameter int unsigned DIM_DUTY = 3,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       press,
    input  logic       rel,
    output logic [3:0] mode,
    output logic       mode_change,
    output logic       led
);

    localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
    localparam int unsigned DUTY_W = DIM_W + 1;

    localparam logic [3:0] M_OFF   = 4'b0001;
    localparam logic [3:0] M_ON    = 4'b0010;
    localparam logic [3:0] M_BLINK = 4'b0100;
    localparam logic [3:0] M_DIM   = 4'b1000;

    // hold_cnt value whose increment reaches LONG_CYC-1
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYC - 2);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);
    localparam logic [DUTY_W-1:0] DUTY      = DUTY_W'(DIM_DUTY);

    // Elaboration-time parameter sanity checks
    if (LONG_CYC < 2) begin : g_bad_long
        $error("LONG_CYC must be at least 2");
    end
    if (DIM_DUTY > (1 << DIM_W)) begin : g_bad_duty
        $error("DIM_DUTY must not exceed 2**DIM_W");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    logic                held;
    logic                consumed;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [BLINK_W-1:0]  blink_cnt;
    logic [DIM_W-1:0]    pwm_cnt;

    logic [3:0]          mode_nxt;
    logic                held_nxt;
    logic                consumed_nxt;
    logic [HOLD_W-1:0]   hold_cnt_nxt;
    logic                long_fire;
    logic                changed;
    logic                led_nxt;

`ifdef BIKELIGHT_AUTO_OFF_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT);
    logic [IDLE_W-1:0]   idle_cnt;
    logic [IDLE_W-1:0]   idle_cnt_nxt;
    logic                timeout_hit;
`endif

    // Press tracking and next-mode decision
    always_comb begin
        mode_nxt     = mode;
        held_nxt     = held;
        consumed_nxt = consumed;
        hold_cnt_nxt = hold_cnt;
        long_fire    = held && !consumed && (hold_cnt == HOLD_FIRE);

        if (held && (hold_cnt != HOLD_MAX)) begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        end

        if (long_fire) begin
            mode_nxt     = M_OFF;
            consumed_nxt = 1'b1;
        end

        if (held && rel) begin
            held_nxt = 1'b0;
            if (!consumed && !long_fire) begin
                mode_nxt = {mode[2:0], mode[3]};
            end
        end else if (!held && press) begin
            if (rel) begin
                mode_nxt = {mode[2:0], mode[3]};
            end else begin
                held_nxt     = 1'b1;
                hold_cnt_nxt = '0;
                consumed_nxt = 1'b0;
            end
        end

`ifdef BIKELIGHT_AUTO_OFF_EN
        // A press in the timeout cycle keeps the light on
        timeout_hit = (mode != M_OFF) && !held && !press &&
                      (idle_cnt == IDLE_W'(TIMEOUT - 1));
        if (timeout_hit) begin
            mode_nxt = M_OFF;
        end
`endif

        if (!$onehot(mode)) begin
            mode_nxt = M_OFF;
        end

        changed = (mode_nxt != mode);

`ifdef BIKELIGHT_AUTO_OFF_EN
        if (press || changed) begin
            idle_cnt_nxt = '0;
        end else if ((mode != M_OFF) && !held) begin
            idle_cnt_nxt = idle_cnt + IDLE_W'(1);
        end else begin
            idle_cnt_nxt = idle_cnt;
        end
`endif
    end

    // LED pattern for the current mode
    always_comb begin
        led_nxt = 1'b0;
        case (mode)
            M_ON:    led_nxt = 1'b1;
            M_BLINK: led_nxt = ~blink_cnt[BLINK_W-1];
            M_DIM:   led_nxt = ({1'b0, pwm_cnt} < DUTY);
            default: led_nxt = 1'b0;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode        <= M_OFF;
            mode_change <= 1'b0;
            led         <= 1'b0;
            held        <= 1'b0;
            consumed    <= 1'b0;
            hold_cnt    <= '0;
            blink_cnt   <= '0;
            pwm_cnt     <= '0;
`ifdef BIKELIGHT_AUTO_OFF_EN
            idle_cnt    <= '0;
`endif
        end else begin
            mode        <= mode_nxt;
            mode_change <= changed;
            led         <= led_nxt;
            held        <= held_nxt;
            consumed    <= consumed_nxt;
            hold_cnt    <= hold_cnt_nxt;
            blink_cnt   <= changed ? '0 : blink_cnt + BLINK_W'(1);
            pwm_cnt     <= changed ? '0 : pwm_cnt + DIM_W'(1);
`ifdef BIKELIGHT_AUTO_OFF_EN
            idle_cnt    <= idle_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_bikelight_mode_ctrl.sv
// Testbench for bikelight_mode_ctrl: directed scenarios plus randomized
// button traffic checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_bikelight_mode_ctrl;

    localparam int unsigned LONG_CYC = 8;
    localparam int unsigned BLINK_W  = 3;
    localparam int unsigned DIM_W    = 2;
    localparam int unsigned DIM_DUTY = 3;
    localparam int unsigned TIMEOUT  = 32;
`ifdef BIKELIGHT_AUTO_OFF_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       press = 1'b0;
    logic       rel   = 1'b0;
    logic [3:0] mode;
    logic       mode_change;
    logic       led;

    int checks = 0;
    int errors = 0;

    // Reference model state: mode index 0=OFF 1=ON 2=BLINK 3=DIM
    int m_mode;
    int m_since;
    int m_idle;
    int m_press_edge;
    int edge_n;
    bit m_held;
    bit m_consumed;
    bit m_led;
    bit m_mc;

    bikelight_mode_ctrl #(
        .LONG_CYC (LONG_CYC),
        .BLINK_W  (BLINK_W),
        .DIM_W    (DIM_W),
        .DIM_DUTY (DIM_DUTY),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .press       (press),
        .rel         (rel),
        .mode        (mode),
        .mode_change (mode_change),
        .led         (led)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] onehot_of(input int idx);
        return 4'(1 << idx);
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        m_since    = 0;
        m_idle     = 0;
        m_held     = 1'b0;
        m_consumed = 1'b0;
        m_led      = 1'b0;
        m_mc       = 1'b0;
    endtask

    // Advance the model by one clock edge with the inputs sampled at that edge
    task automatic model_step(input bit p, input bit r);
        int  nm;
        bit  lf;
        bit  to;
        bit  held_old;
        int  half;
        int  per;
        half = 1 << (BLINK_W - 1);
        per  = 1 << DIM_W;
        m_led = (m_mode == 1) ||
                (m_mode == 2 && (m_since % (2 * half)) < half) ||
                (m_mode == 3 && (m_since % per) < int'(DIM_DUTY));
        held_old = m_held;
        nm = m_mode;
        lf = m_held && !m_consumed && (edge_n == m_press_edge + int'(LONG_CYC) - 1);
        if (lf) nm = 0;
        if (m_held && r) begin
            if (!lf && !m_consumed) nm = (m_mode + 1) % 4;
            m_held = 1'b0;
        end else if (!m_held && p && r) begin
            nm = (m_mode + 1) % 4;
        end else if (!m_held && p) begin
            m_held       = 1'b1;
            m_press_edge = edge_n;
            m_consumed   = 1'b0;
        end
        if (lf) m_consumed = 1'b1;
        to = AUTO && (m_mode != 0) && !held_old && !p && (m_idle == int'(TIMEOUT) - 1);
        if (to) nm = 0;
        m_mc = (nm != m_mode);
        if (p || m_mc) m_idle = 0;
        else if (m_mode != 0 && !held_old) m_idle = m_idle + 1;
        m_since = m_mc ? 0 : m_since + 1;
        m_mode  = nm;
        edge_n  = edge_n + 1;
    endtask

    // Drive one cycle of button pulses; outputs are valid 1ns after the edge
    task automatic tick(input bit p, input bit r);
        press = p;
        rel   = r;
        @(posedge clk);
        model_step(p, r);
        #1;
        press = 1'b0;
        rel   = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (mode !== 4'b0001) begin errors++; $display("FAIL reset_mode got=%b exp=0001", mode); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led got=%b exp=0", led); end
        checks++; if (mode_change !== 1'b0) begin errors++; $display("FAIL reset_mc got=%b exp=0", mode_change); end
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL pre_reset_led got=%b exp=1", led); end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (mode !== 4'b0001) begin errors++; $display("FAIL async_reset_mode got=%b exp=0001", mode); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL async_reset_led got=%b exp=0", led); end
        checks++; if (mode_change !== 1'b0) begin errors++; $display("FAIL async_reset_mc got=%b exp=0", mode_change); end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick(1'b0, 1'b1);
        checks++; if (mode !== 4'b0001) begin errors++; $display("FAIL discarded_press_mode got=%b exp=0001", mode); end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            checks++; if (mode !== 4'b0001 || mode_change !== 1'b0) begin
                errors++; $display("FAIL idle_after_reset i=%0d mode=%b mc=%b exp=0001/0", i, mode, mode_change);
            end
        end
    endtask

    task automatic test_short_press();
        logic [3:0] exp_seq [4];
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
            checks++; if (mode_change !== 1'b0) begin errors++; $display("FAIL short_hold_mc i=%0d got=%b exp=0", i, mode_change); end
            tick(1'b0, 1'b1);
            checks++; if (mode !== exp_seq[i]) begin errors++; $display("FAIL short_step i=%0d got=%b exp=%b", i, mode, exp_seq[i]); end
            checks++; if (mode_change !== 1'b1) begin errors++; $display("FAIL short_mc i=%0d got=%b exp=1", i, mode_change); end
            tick(1'b0, 1'b0);
            checks++; if (mode_change !== 1'b0) begin errors++; $display("FAIL short_mc_pulse i=%0d got=%b exp=0", i, mode_change); end
        end
    endtask

    task automatic test_long_press();
        logic [3:0] exp_m;
        do_reset();
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        checks++; if (mode !== 4'b0010) begin errors++; $display("FAIL long_start got=%b exp=0010", mode); end
        for (int k = 1; k < 20; k++) begin
            tick(1'b0, 1'b0);
            exp_m = (k >= int'(LONG_CYC) - 1) ? 4'b0001 : 4'b0010;
            checks++; if (mode !== exp_m || mode_change !== (k == int'(LONG_CYC) - 1)) begin
                errors++; $display("FAIL long_hold k=%0d mode=%b mc=%b exp=%b/%b", k, mode, mode_change, exp_m, (k == int'(LONG_CYC) - 1));
            end
        end
        tick(1'b0, 1'b1);
        checks++; if (mode !== 4'b0001 || mode_change !== 1'b0) begin
            errors++; $display("FAIL long_release mode=%b mc=%b exp=0001/0", mode, mode_change);
        end
        tick(1'b1, 1'b0);
        for (int k = 1; k < 12; k++) begin
            tick(1'b0, 1'b0);
            checks++; if (mode !== 4'b0001 || mode_change !== 1'b0) begin
                errors++; $display("FAIL long_in_off k=%0d mode=%b mc=%b exp=0001/0", k, mode, mode_change);
            end
        end
        tick(1'b0, 1'b1);
        checks++; if (mode !== 4'b0001 || mode_change !== 1'b0) begin
            errors++; $display("FAIL long_off_release mode=%b mc=%b exp=0001/0", mode, mode_change);
        end
    endtask

    task automatic test_led_patterns();
        bit exp_led;
        do_reset();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        checks++; if (mode !== 4'b0100) begin errors++; $display("FAIL blink_entry got=%b exp=0100", mode); end
        for (int j = 0; j < 16; j++) begin
            tick(1'b0, 1'b0);
            exp_led = (j % 8) < 4;
            checks++; if (led !== exp_led) begin errors++; $display("FAIL blink_led j=%0d got=%b exp=%b", j, led, exp_led); end
        end
        tick(1'b1, 1'b1);
        checks++; if (mode !== 4'b1000) begin errors++; $display("FAIL dim_entry got=%b exp=1000", mode); end
        for (int j = 0; j < 12; j++) begin
            tick(1'b0, 1'b0);
            exp_led = (j % 4) < int'(DIM_DUTY);
            checks++; if (led !== exp_led) begin errors++; $display("FAIL dim_led j=%0d got=%b exp=%b", j, led, exp_led); end
        end
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL off_led got=%b exp=0", led); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        tick(1'b1, 1'b1);
        checks++; if (mode !== 4'b0010 || mode_change !== 1'b1) begin
            errors++; $display("FAIL same_cycle mode=%b mc=%b exp=0010/1", mode, mode_change);
        end
        tick(1'b0, 1'b1);
        checks++; if (mode !== 4'b0010 || mode_change !== 1'b0) begin
            errors++; $display("FAIL stray_release mode=%b mc=%b exp=0010/0", mode, mode_change);
        end
        tick(1'b0, 1'b0);
        checks++; if (mode !== 4'b0010 || mode_change !== 1'b0) begin
            errors++; $display("FAIL stray_release_after mode=%b mc=%b exp=0010/0", mode, mode_change);
        end
    endtask

    task automatic test_auto_off();
        do_reset();
        tick(1'b1, 1'b1);
        if (AUTO) begin
            for (int j = 1; j < int'(TIMEOUT); j++) begin
                tick(1'b0, 1'b0);
                checks++; if (mode !== 4'b0010) begin errors++; $display("FAIL auto_wait j=%0d got=%b exp=0010", j, mode); end
            end
            tick(1'b0, 1'b0);
            checks++; if (mode !== 4'b0001 || mode_change !== 1'b1) begin
                errors++; $display("FAIL auto_off mode=%b mc=%b exp=0001/1", mode, mode_change);
            end
            tick(1'b1, 1'b1);
            for (int j = 1; j < int'(TIMEOUT); j++) tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
            checks++; if (mode !== 4'b0010 || mode_change !== 1'b0) begin
                errors++; $display("FAIL auto_press_wins mode=%b mc=%b exp=0010/0", mode, mode_change);
            end
            tick(1'b0, 1'b0);
            checks++; if (mode !== 4'b0010) begin errors++; $display("FAIL auto_held got=%b exp=0010", mode); end
            tick(1'b0, 1'b1);
            checks++; if (mode !== 4'b0100) begin errors++; $display("FAIL auto_step got=%b exp=0100", mode); end
        end else begin
            for (int j = 0; j < 100; j++) begin
                tick(1'b0, 1'b0);
                checks++; if (mode !== 4'b0010 || mode_change !== 1'b0) begin
                    errors++; $display("FAIL persist j=%0d mode=%b mc=%b exp=0010/0", j, mode, mode_change);
                end
            end
        end
    endtask

    task automatic test_random();
        bit p;
        bit r;
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            p = ($urandom % 10) == 0;
            r = ($urandom % 6) == 0;
            tick(p, r);
            checks++; if (mode !== onehot_of(m_mode)) begin
                errors++; $display("FAIL rand_mode t=%0d got=%b exp=%b", t, mode, onehot_of(m_mode));
            end
            checks++; if (led !== m_led) begin
                errors++; $display("FAIL rand_led t=%0d got=%b exp=%b", t, led, m_led);
            end
            checks++; if (mode_change !== m_mc) begin
                errors++; $display("FAIL rand_mc t=%0d got=%b exp=%b", t, mode_change, m_mc);
            end
        end
    endtask

    initial begin
        edge_n       = 0;
        m_press_edge = 0;
        model_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        test_reset();
        test_short_press();
        test_long_press();
        test_led_patterns();
        test_same_cycle();
        test_auto_off();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
